// File: rtl/demux2to1_9_if.sv
// Handshake bundle for the 1-to-2 word demultiplexer:
// one tagged input stream and two output channels.
interface demux2to1_9_if #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out_a;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] out_b;
  logic             b_valid;
  logic             b_ready;
  logic [CNT_W-1:0] cnt_a;
  logic [CNT_W-1:0] cnt_b;

  modport slave (
    input  in_data, in_sel, in_valid,
    input  a_ready, b_ready,
    output in_ready,
    output out_a, a_valid,
    output out_b, b_valid,
    output cnt_a, cnt_b
  );

  modport master (
    output in_data, in_sel, in_valid,
    output a_ready, b_ready,
    input  in_ready,
    input  out_a, a_valid,
    input  out_b, b_valid,
    input  cnt_a, cnt_b
  );
endinterface

// File: rtl/demux2to1_9.sv
// Registered 1-to-2 demux: steers tagged words to channel A or B,
// each with a one-word holding register and a delivered-word counter.
module demux2to1_9 #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 8
) (
  input logic           clk,
  input logic           rst,
  demux2to1_9_if.slave  bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_st_e;

  ch_st_e st_a;
  ch_st_e st_b;

  logic rdy_a;
  logic rdy_b;
  logic acc_a;
  logic acc_b;
  logic del_a;
  logic del_b;

  assign bus.a_valid = (st_a == FULL);
  assign bus.b_valid = (st_b == FULL);

  // Readiness only looks at the tagged channel, so a
  // stalled channel never blocks the other one.
  assign rdy_a = !bus.a_valid || bus.a_ready;
  assign rdy_b = !bus.b_valid || bus.b_ready;
  assign bus.in_ready = bus.in_sel ? rdy_b : rdy_a;

  assign acc_a = bus.in_valid && !bus.in_sel && rdy_a;
  assign acc_b = bus.in_valid &&  bus.in_sel && rdy_b;
  assign del_a = bus.a_valid && bus.a_ready;
  assign del_b = bus.b_valid && bus.b_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_a      <= EMPTY;
      st_b      <= EMPTY;
      bus.out_a <= '0;
      bus.out_b <= '0;
      bus.cnt_a <= '0;
      bus.cnt_b <= '0;
    end else begin
      unique case (st_a)
        EMPTY: begin
          if (acc_a) begin
            st_a      <= FULL;
            bus.out_a <= bus.in_data;
          end
        end
        FULL: begin
          if (acc_a) begin
            bus.out_a <= bus.in_data;
          end else if (del_a) begin
            st_a <= EMPTY;
          end
        end
        default: st_a <= EMPTY;
      endcase

      unique case (st_b)
        EMPTY: begin
          if (acc_b) begin
            st_b      <= FULL;
            bus.out_b <= bus.in_data;
          end
        end
        FULL: begin
          if (acc_b) begin
            bus.out_b <= bus.in_data;
          end else if (del_b) begin
            st_b <= EMPTY;
          end
        end
        default: st_b <= EMPTY;
      endcase

      // Counters wrap freely at 2^CNT_W.
      if (del_a) bus.cnt_a <= bus.cnt_a + CNT_W'(1);
      if (del_b) bus.cnt_b <= bus.cnt_b + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_demux2to1_9.sv
// Bench for demux2to1_9: directed scenarios plus a randomized
// run against a queue-based channel model.
module tb_demux2to1_9;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  demux2to1_9_if bus ();

  demux2to1_9 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.in_data  = '0;
    bus.in_sel   = 1'b0;
    bus.in_valid = 1'b0;
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #2;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0 ||
        bus.out_a !== 9'd0 || bus.out_b !== 9'd0 ||
        bus.cnt_a !== 8'd0 || bus.cnt_b !== 8'd0) begin
      errors++;
      $display("FAIL reset_init: av=%b bv=%b oa=%0d ob=%0d ca=%0d cb=%0d want all 0",
               bus.a_valid, bus.b_valid, bus.out_a, bus.out_b,
               bus.cnt_a, bus.cnt_b);
    end
    @(negedge clk);
    rst = 1'b0;
    cyc();
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 9'd7;
    cyc();
    bus.in_sel  = 1'b1;
    bus.in_data = 9'd9;
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.a_valid !== 1'b1 || bus.b_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_fill: av=%b bv=%b want 1 1",
               bus.a_valid, bus.b_valid);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.a_valid !== 1'b0 || bus.b_valid !== 1'b0 ||
        bus.out_a !== 9'd0 || bus.out_b !== 9'd0 ||
        bus.cnt_a !== 8'd0 || bus.cnt_b !== 8'd0) begin
      errors++;
      $display("FAIL reset_async: av=%b bv=%b oa=%0d ob=%0d ca=%0d cb=%0d want all 0",
               bus.a_valid, bus.b_valid, bus.out_a, bus.out_b,
               bus.cnt_a, bus.cnt_b);
    end
    bus.in_sel = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy_a: in_ready=%b want 1", bus.in_ready);
    end
    bus.in_sel = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_rdy_b: in_ready=%b want 1", bus.in_ready);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_routing();
    do_reset();
    bus.a_ready  = 1'b1;
    bus.b_ready  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 9'd50;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL route_rdy: in_ready=%b want 1", bus.in_ready);
    end
    cyc();
    checks++;
    if (bus.a_valid !== 1'b1 || bus.out_a !== 9'd50 ||
        bus.b_valid !== 1'b0) begin
      errors++;
      $display("FAIL route_a: av=%b oa=%0d bv=%b want 1 50 0",
               bus.a_valid, bus.out_a, bus.b_valid);
    end
    bus.in_sel  = 1'b1;
    bus.in_data = 9'd90;
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.b_valid !== 1'b1 || bus.out_b !== 9'd90 ||
        bus.a_valid !== 1'b0 || bus.out_a !== 9'd50 ||
        bus.cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL route_b: bv=%b ob=%0d av=%b oa=%0d ca=%0d want 1 90 0 50 1",
               bus.b_valid, bus.out_b, bus.a_valid, bus.out_a, bus.cnt_a);
    end
    cyc();
    checks++;
    if (bus.b_valid !== 1'b0 || bus.cnt_a !== 8'd1 ||
        bus.cnt_b !== 8'd1 || bus.out_a !== 9'd50) begin
      errors++;
      $display("FAIL route_cnt: bv=%b ca=%0d cb=%0d oa=%0d want 0 1 1 50",
               bus.b_valid, bus.cnt_a, bus.cnt_b, bus.out_a);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.a_ready  = 1'b0;
    bus.b_ready  = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 9'd50;
    cyc();
    bus.in_data = 9'd90;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall: in_ready=%b want 0", bus.in_ready);
    end
    cyc();
    checks++;
    if (bus.a_valid !== 1'b1 || bus.out_a !== 9'd50) begin
      errors++;
      $display("FAIL bp_hold: av=%b oa=%0d want 1 50",
               bus.a_valid, bus.out_a);
    end
    bus.in_sel = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_iso_rdy: in_ready=%b want 1", bus.in_ready);
    end
    cyc();
    checks++;
    if (bus.b_valid !== 1'b1 || bus.out_b !== 9'd90 ||
        bus.out_a !== 9'd50 || bus.a_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_iso: bv=%b ob=%0d av=%b oa=%0d want 1 90 1 50",
               bus.b_valid, bus.out_b, bus.a_valid, bus.out_a);
    end
    bus.in_sel  = 1'b0;
    bus.a_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_rdy: in_ready=%b want 1", bus.in_ready);
    end
    cyc();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.a_valid !== 1'b1 || bus.out_a !== 9'd90 ||
        bus.cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL bp_drain1: av=%b oa=%0d ca=%0d want 1 90 1",
               bus.a_valid, bus.out_a, bus.cnt_a);
    end
    cyc();
    checks++;
    if (bus.a_valid !== 1'b0 || bus.cnt_a !== 8'd2 ||
        bus.cnt_b !== 8'd1) begin
      errors++;
      $display("FAIL bp_drain2: av=%b ca=%0d cb=%0d want 0 2 1",
               bus.a_valid, bus.cnt_a, bus.cnt_b);
    end
  endtask

  task automatic test_load_drain();
    do_reset();
    bus.in_valid = 1'b1;
    bus.in_sel   = 1'b0;
    bus.in_data  = 9'd50;
    cyc();
    bus.a_ready = 1'b1;
    bus.in_data = 9'd51;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL ld_rdy: in_ready=%b want 1", bus.in_ready);
    end
    cyc();
    bus.in_valid = 1'b0;
    bus.a_ready  = 1'b0;
    checks++;
    if (bus.a_valid !== 1'b1 || bus.out_a !== 9'd51 ||
        bus.cnt_a !== 8'd1) begin
      errors++;
      $display("FAIL ld_swap: av=%b oa=%0d ca=%0d want 1 51 1",
               bus.a_valid, bus.out_a, bus.cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    int stalls;
    stalls = 0;
    do_reset();
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 9'(i);
      bus.in_sel   = i[0];
      #1;
      if (bus.in_ready !== 1'b1) stalls++;
      cyc();
      checks++;
      if (i % 2 == 0) begin
        if (bus.a_valid !== 1'b1 || bus.out_a !== 9'(i)) begin
          errors++;
          $display("FAIL stream_a[%0d]: av=%b oa=%0d want 1 %0d",
                   i, bus.a_valid, bus.out_a, i);
        end
      end else begin
        if (bus.b_valid !== 1'b1 || bus.out_b !== 9'(i)) begin
          errors++;
          $display("FAIL stream_b[%0d]: bv=%b ob=%0d want 1 %0d",
                   i, bus.b_valid, bus.out_b, i);
        end
      end
    end
    bus.in_valid = 1'b0;
    cyc();
    checks++;
    if (bus.cnt_a !== 8'd10 || bus.cnt_b !== 8'd10 || stalls != 0) begin
      errors++;
      $display("FAIL stream_end: ca=%0d cb=%0d stalls=%0d want 10 10 0",
               bus.cnt_a, bus.cnt_b, stalls);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    bus.b_ready = 1'b1;
    bus.in_sel  = 1'b1;
    for (int i = 0; i < 257; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 9'(i);
      cyc();
      if (i == 255) begin
        checks++;
        if (bus.cnt_b !== 8'd255) begin
          errors++;
          $display("FAIL wrap_255: cnt_b=%0d want 255", bus.cnt_b);
        end
      end
      if (i == 256) begin
        checks++;
        if (bus.cnt_b !== 8'd0) begin
          errors++;
          $display("FAIL wrap_0: cnt_b=%0d want 0", bus.cnt_b);
        end
      end
    end
    bus.in_valid = 1'b0;
    cyc();
    checks++;
    if (bus.cnt_b !== 8'd1 || bus.cnt_a !== 8'd0) begin
      errors++;
      $display("FAIL wrap_end: cb=%0d ca=%0d want 1 0",
               bus.cnt_b, bus.cnt_a);
    end
  endtask

  task automatic test_random();
    logic [8:0] qa[$];
    logic [8:0] qb[$];
    logic [8:0] ra, rb, d;
    logic       v, s, er, hold;
    int         ca, cb;
    ra = '0; rb = '0; ca = 0; cb = 0;
    hold = 1'b0; v = 1'b0; s = 1'b0; d = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (bus.a_valid !== (qa.size() != 0) || bus.out_a !== ra ||
          bus.cnt_a !== 8'(ca)) begin
        errors++;
        $display("FAIL rand_a[%0d]: av=%b oa=%0d ca=%0d want %b %0d %0d",
                 c, bus.a_valid, bus.out_a, bus.cnt_a,
                 qa.size() != 0, ra, ca);
      end
      checks++;
      if (bus.b_valid !== (qb.size() != 0) || bus.out_b !== rb ||
          bus.cnt_b !== 8'(cb)) begin
        errors++;
        $display("FAIL rand_b[%0d]: bv=%b ob=%0d cb=%0d want %b %0d %0d",
                 c, bus.b_valid, bus.out_b, bus.cnt_b,
                 qb.size() != 0, rb, cb);
      end
      if (!hold) begin
        v = ($urandom % 4) != 0;
        s = $urandom_range(0, 1) == 1;
        d = 9'($urandom);
      end
      bus.in_valid = v;
      bus.in_sel   = s;
      bus.in_data  = d;
      bus.a_ready  = ($urandom % 3) != 0;
      bus.b_ready  = ($urandom % 3) == 0;
      #1;
      er = s ? (qb.size() == 0 || bus.b_ready)
             : (qa.size() == 0 || bus.a_ready);
      checks++;
      if (bus.in_ready !== er) begin
        errors++;
        $display("FAIL rand_rdy[%0d]: in_ready=%b want %b",
                 c, bus.in_ready, er);
      end
      if (qa.size() != 0 && bus.a_ready) begin
        void'(qa.pop_front());
        ca = (ca + 1) % 256;
      end
      if (qb.size() != 0 && bus.b_ready) begin
        void'(qb.pop_front());
        cb = (cb + 1) % 256;
      end
      if (v && er) begin
        if (s) begin
          qb.push_back(d);
          rb = d;
        end else begin
          qa.push_back(d);
          ra = d;
        end
      end
      hold = v && !er;
      cyc();
    end
    idle_inputs();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    clk = 1'b0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_routing();
    test_backpressure();
    test_load_drain();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux2to1_9.md
# demux2to1_9

Registered 1-to-2 demultiplexer with valid/ready handshakes on all three ports. It takes a single 9-bit word stream tagged with a select bit and steers each word to channel A (`in_sel=0`) or channel B (`in_sel=1`). It is the receiving end of the 2:1 word multiplexer: it splits a shared bus back into its two source channels. Each output channel has a one-word holding register and a delivered-word counter.

## Interface
Parameters:
- `WIDTH`, 9, data word width for the input and both outputs.
- `CNT_W`, 8, width of each per-channel delivered-word counter.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_data`  in  WIDTH  input word.
- `in_sel`  in  1  destination tag: 0 selects A, 1 selects B.
- `in_valid`  in  1  input word and tag are valid.
- `in_ready`  out  1  block can accept the input word this cycle (combinational).
- `out_a`  out  WIDTH  channel A data register.
- `a_valid`  out  1  `out_a` holds an undelivered word.
- `a_ready`  in  1  channel A consumer accepts.
- `out_b`  out  WIDTH  channel B data register.
- `b_valid`  out  1  `out_b` holds an undelivered word.
- `b_ready`  in  1  channel B consumer accepts.
- `cnt_a`  out  CNT_W  count of words delivered on A.
- `cnt_b`  out  CNT_W  count of words delivered on B.

## Operation
- Each channel is a two-state machine:
  - EMPTY (valid=0).
  - FULL (valid=1).
- Input handshake: `acc = in_valid & in_ready`.
- `in_ready = in_sel ? (!b_valid | b_ready) : (!a_valid | a_ready)`.
  - Depends only on the tag and the *selected* channel.
  - A stalled channel never blocks words tagged for the other channel.
- Output handshake on channel X: `del_X = X_valid & X_ready`.
- Channel X transitions, evaluated each edge:
  - EMPTY, acc to X → FULL; `out_X` ← `in_data`.
  - FULL, del_X and no acc to X → EMPTY; `out_X` keeps its last value (not cleared).
  - FULL, del_X and acc to X (same cycle) → stays FULL; `out_X` ← new word. Back-to-back throughput is one word per cycle per channel.
  - FULL, no del_X → stays FULL; `out_X` and valid are held stable. `in_ready` is 0 for words tagged X.
- A word tagged for the non-selected channel never alters the other channel's register or valid.
- Counters: `cnt_X` increments by 1 on each `del_X`.
  - Modulo 2^CNT_W: 255 → 0 at the default width, with no saturation and no flag.
- `in_data`/`in_sel` are ignored when `in_valid=0`.
- A transfer is not possible when `in_ready=0`. The producer must hold `in_data` and `in_sel` stable until accepted.

## Timing
- Reset (async assert, any time): `a_valid`, `b_valid`, `out_a`, `out_b`, `cnt_a`, `cnt_b` all go to 0 immediately.
  - `in_ready` then evaluates to 1 for both tags.
  - A word held in a FULL register at reset assertion is discarded, not delivered and not counted.
- Reset deassertion: first handshake can occur on the first rising edge with `rst=0`.
- Latency: a word accepted at edge N appears on `out_X` with `X_valid=1` immediately after edge N. The earliest delivery is edge N+1.
- Sustained rate:
  - 1 word/cycle aggregate when the targeted consumer is ready.
  - Alternating tags sustain 1 word/cycle with each channel receiving every other cycle.
- `in_ready` has a combinational path from `in_sel`, `a_ready`, `b_ready`, `a_valid`, `b_valid`. No other combinational input-to-output paths.
- Counter update is in the same edge as its delivery: `cnt_X` reflects the delivery from edge N immediately after edge N.

## Test plan
- Reset: assert `rst` mid-cycle with both channels FULL. Required: all outputs 0 asynchronously; `in_ready=1`; no count increments.
- Single routing: `in_data=50, in_sel=0, in_valid=1` for one cycle, then `in_data=90, in_sel=1` for one cycle, `a_ready=b_ready=1`. Required:
  - `out_a=50, a_valid` for one cycle, then `out_b=90, b_valid` for one cycle.
  - `cnt_a=1, cnt_b=1`.
  - `out_a` still reads 50 after delivery.
- Backpressure isolation: `a_ready=0`, send 50 to A, then 90 to A, then 90 to B. Required:
  - A holds 50 with `in_ready=0` for the second A word.
  - B word accepted, and `b_valid` rises the next cycle.
  - Raising `a_ready` delivers 50, then 90.
- Simultaneous load/drain: channel A FULL with 50, `a_ready=1`, new word 51 to A in the same cycle. Required: `a_valid` stays 1, `out_a=51` next cycle, `cnt_a` +1, no bubble.
- Streaming: 20 back-to-back words 0..19 with alternating tags, both ready. Required:
  - A receives even values in order, B receives odd values in order.
  - `cnt_a=cnt_b=10`; `in_ready` is never 0.
- Counter wrap: deliver 257 words to B. Required: `cnt_b` reaches 255, wraps to 0, ends at 1; `cnt_a` stays 0.
